// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and elaboration helpers for the LCD character writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    EN_HI,
    EXEC,
    WRAP
  } lcd_state_t;

  // Origin of the byte currently on the bus; selects what happens after EXEC.
  typedef enum logic [1:0] {
    SRC_INIT,
    SRC_DATA,
    SRC_CMD,
    SRC_WRAP
  } lcd_src_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE0    = 8'h80;
  localparam logic [7:0] LCD_LINE1    = 8'hC0;
  localparam logic [7:0] CHAR_FF      = 8'h0C;

  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_CLEAR;
      default: cmd = LCD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_char_writer.sv
// Accepts ASCII bytes over valid/ready and writes them to an HD44780 16x2 LCD,
// handling power-up init, RS/EN timing, form feed and automatic line wrap.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned PWRUP_CYC = CLK_FREQ / 25,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EN_CYC    = CLK_FREQ / 1_000_000,
  parameter int unsigned EXEC_CYC  = CLK_FREQ / 20_000,
  parameter int unsigned CLEAR_CYC = CLK_FREQ / 500,
  parameter int unsigned COLS      = 16
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy
);

  localparam int unsigned PWR_N   = at_least_one(PWRUP_CYC);
  localparam int unsigned SETUP_N = at_least_one(SETUP_CYC);
  localparam int unsigned EN_N    = at_least_one(EN_CYC);
  localparam int unsigned EXEC_N  = at_least_one(EXEC_CYC);
  localparam int unsigned CLEAR_N = at_least_one(CLEAR_CYC);
  localparam int unsigned MAX_N   = max_u(max_u(PWR_N, SETUP_N), max_u(max_u(EN_N, EXEC_N), CLEAR_N));
  localparam int unsigned CNT_W   = $clog2(MAX_N) + 1;
  localparam int unsigned COL_W   = $clog2(COLS + 1);

  // The counter leaves reset at 0 and counts down through wrap-around during
  // power-up, so PWRUP ends at the two's-complement of PWR_N-1 (PWR_N cycles).
  localparam logic [CNT_W-1:0] PWR_END = CNT_W'((64'd1 << CNT_W) - 64'(PWR_N - 1));

  lcd_state_t       state, state_n;
  lcd_src_t         src, src_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       init_idx, init_idx_n;
  logic [COL_W-1:0] col, col_n;
  logic             line, line_n;
  logic             clear_wait, clear_wait_n;
  logic             ld;
  logic [7:0]       ld_byte;
  logic             ld_rs;
  lcd_src_t         ld_src;

  always_comb begin
    state_n      = state;
    src_n        = src;
    cnt_n        = cnt;
    init_idx_n   = init_idx;
    col_n        = col;
    line_n       = line;
    clear_wait_n = clear_wait;
    ld           = 1'b0;
    ld_byte      = '0;
    ld_rs        = 1'b0;
    ld_src       = src;

    case (state)
      PWRUP: begin
        if (cnt == PWR_END) begin
          state_n    = INIT;
          init_idx_n = '0;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      INIT: begin
        ld      = 1'b1;
        ld_byte = init_cmd(init_idx);
        ld_rs   = 1'b0;
        ld_src  = SRC_INIT;
      end

      IDLE: begin
        if (char_valid && char_ready) begin
          ld = 1'b1;
          if (char_in == CHAR_FF) begin
            ld_byte = LCD_CLEAR;
            ld_rs   = 1'b0;
            ld_src  = SRC_CMD;
          end else begin
            ld_byte = char_in;
            ld_rs   = 1'b1;
            ld_src  = SRC_DATA;
          end
        end
      end

      WRAP: begin
        ld      = 1'b1;
        ld_byte = line ? LCD_LINE1 : LCD_LINE0;
        ld_rs   = 1'b0;
        ld_src  = SRC_WRAP;
      end

      SETUP: begin
        if (cnt == '0) begin
          state_n = EN_HI;
          cnt_n   = CNT_W'(EN_N - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      EN_HI: begin
        if (cnt == '0) begin
          state_n = EXEC;
          // EXEC spends one extra hold cycle before the wait proper.
          cnt_n   = clear_wait ? CNT_W'(CLEAR_N) : CNT_W'(EXEC_N);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      EXEC: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          case (src)
            SRC_INIT: begin
              if (init_idx == 2'd3) begin
                state_n = IDLE;
              end else begin
                init_idx_n = init_idx + 1'b1;
                state_n    = INIT;
              end
            end
            SRC_DATA: begin
              if (col == COL_W'(COLS - 1)) begin
                col_n   = '0;
                line_n  = ~line;
                state_n = WRAP;
              end else begin
                col_n   = col + 1'b1;
                state_n = IDLE;
              end
            end
            SRC_CMD: begin
              col_n   = '0;
              line_n  = 1'b0;
              state_n = IDLE;
            end
            default: state_n = IDLE;
          endcase
        end
      end

      default: state_n = PWRUP;
    endcase

    if (ld) begin
      state_n      = SETUP;
      src_n        = ld_src;
      cnt_n        = CNT_W'(SETUP_N - 1);
      clear_wait_n = !ld_rs && (ld_byte == LCD_CLEAR);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= PWRUP;
      src        <= SRC_INIT;
      cnt        <= '0;
      init_idx   <= '0;
      col        <= '0;
      line       <= 1'b0;
      clear_wait <= 1'b0;
      lcd_data   <= '0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      char_ready <= 1'b0;
    end else begin
      state      <= state_n;
      src        <= src_n;
      cnt        <= cnt_n;
      init_idx   <= init_idx_n;
      col        <= col_n;
      line       <= line_n;
      clear_wait <= clear_wait_n;
      lcd_en     <= (state_n == EN_HI);
      char_ready <= (state_n == IDLE);
      if (ld) begin
        lcd_data <= ld_byte;
        lcd_rs   <= ld_rs;
      end
    end
  end

  assign lcd_rw = 1'b0;
  assign busy   = (state != IDLE);

endmodule
